// File: rtl/axi_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes and
// helpers that derive address-decode widths from the bank parameters.
package axi_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-address bits below the word index: 2 for 32-bit data, 3 for 64-bit.
    function automatic int addr_lsb(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

    // Bits needed to index n entries, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_lite_hold.sv
// One-entry valid/ready holding register. The upstream side sees ready
// whenever the slot is empty; the slot is freed by the consume strobe.
module axi_lite_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             consume,
    output logic             held,
    output logic [WIDTH-1:0] held_data
);

    logic             held_r;
    logic [WIDTH-1:0] data_r;

    assign in_ready  = ~held_r;
    assign held      = held_r;
    assign held_data = data_r;

    // Capture a beat when the slot is empty; release it when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (in_valid && !held_r) begin
            held_r <= 1'b1;
            data_r <= in_data;
        end else if (consume) begin
            held_r <= 1'b0;
        end else begin
            held_r <= held_r;
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: N_RO read-only status words followed by N_RW
// read/write control words. AW and W are buffered independently and a write
// commits once both are held and no B response is outstanding.
// Optional feature: define AXI_REGBANK_SNAPSHOT_EN so that a read of index 0
// freezes all status words into a shadow bank served to reads of 1..N_RO-1.
module axi_lite_regbank
    import axi_regbank_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int N_RO           = 4,
    parameter int N_RW           = 4,
    parameter logic [AXI_DATA_WIDTH-1:0] RW_RESET = {AXI_DATA_WIDTH{1'b0}}
) (
    input  logic                                        S_AXI_ACLK,
    input  logic                                        S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
    input  logic [2:0]                                  S_AXI_AWPROT,
    input  logic                                        S_AXI_AWVALID,
    output logic                                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]                   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
    input  logic                                        S_AXI_WVALID,
    output logic                                        S_AXI_WREADY,
    output logic [1:0]                                  S_AXI_BRESP,
    output logic                                        S_AXI_BVALID,
    input  logic                                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
    input  logic [2:0]                                  S_AXI_ARPROT,
    input  logic                                        S_AXI_ARVALID,
    output logic                                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]                   S_AXI_RDATA,
    output logic [1:0]                                  S_AXI_RRESP,
    output logic                                        S_AXI_RVALID,
    input  logic                                        S_AXI_RREADY,
    input  logic [N_RO*AXI_DATA_WIDTH-1:0]              ro_data,
    output logic [((N_RW < 1) ? 1 : N_RW)*AXI_DATA_WIDTH-1:0] rw_data,
    output logic [((N_RW < 1) ? 1 : N_RW)-1:0]          wr_pulse
);

    localparam int DW        = AXI_DATA_WIDTH;
    localparam int SW        = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB  = addr_lsb(AXI_DATA_WIDTH);
    localparam int NRW_EFF   = (N_RW < 1) ? 1 : N_RW;
    localparam int RW_SEL_W  = idx_w(NRW_EFF);
    localparam logic [31:0] N_RO_U = 32'(N_RO);
    localparam logic [31:0] N_RW_U = 32'(N_RW);

    logic                      aw_held_s, w_held_s, commit_s, wr_ok_s, ar_hs_s;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_s;
    logic [DW-1:0]             w_data_s, rd_data_s;
    logic [SW-1:0]             w_strb_s;
    logic [31:0]               aw_idx_s, ar_idx_s;
    logic [RW_SEL_W-1:0]       rw_sel_s;
    logic [1:0]                rd_resp_s;
    logic                      unused_s;

    logic [DW-1:0]             rw_r [NRW_EFF];
    logic [NRW_EFF-1:0]        wr_pulse_r;
    logic                      bvalid_r, rvalid_r;
    logic [1:0]                bresp_r, rresp_r;
    logic [DW-1:0]             rdata_r;

    axi_lite_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_hold (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .in_valid  (S_AXI_AWVALID),
        .in_ready  (S_AXI_AWREADY),
        .in_data   (S_AXI_AWADDR),
        .consume   (commit_s),
        .held      (aw_held_s),
        .held_data (aw_addr_s)
    );

    axi_lite_hold #(.WIDTH(DW + SW)) u_w_hold (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .in_valid  (S_AXI_WVALID),
        .in_ready  (S_AXI_WREADY),
        .in_data   ({S_AXI_WSTRB, S_AXI_WDATA}),
        .consume   (commit_s),
        .held      (w_held_s),
        .held_data ({w_strb_s, w_data_s})
    );

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        aw_addr_s[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Write decode: commit when both halves are held and B is free.
    always_comb begin
        aw_idx_s = 32'(aw_addr_s[AXI_ADDR_WIDTH-1:ADDR_LSB]);
        commit_s = aw_held_s & w_held_s & ~bvalid_r;
        wr_ok_s  = (aw_idx_s >= N_RO_U) && (aw_idx_s < (N_RO_U + N_RW_U));
        rw_sel_s = RW_SEL_W'(aw_idx_s - N_RO_U);
    end

    assign ar_hs_s = S_AXI_ARVALID & ~rvalid_r;

`ifdef AXI_REGBANK_SNAPSHOT_EN
    logic [N_RO*DW-1:0] shadow_r;

    // Freeze every status word when index 0 is read.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shadow_r <= {(N_RO*DW){1'b0}};
        end else if (ar_hs_s && (ar_idx_s == 32'd0)) begin
            shadow_r <= ro_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    // Read mux: status (live or shadowed), control, or SLVERR with zero data.
    always_comb begin
        ar_idx_s  = 32'(S_AXI_ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB]);
        rd_data_s = {DW{1'b0}};
        rd_resp_s = RESP_SLVERR;
        if (ar_idx_s < N_RO_U) begin
            rd_resp_s = RESP_OKAY;
            for (int k = 0; k < N_RO; k++) begin
`ifdef AXI_REGBANK_SNAPSHOT_EN
                rd_data_s = (ar_idx_s != 32'(k)) ? rd_data_s :
                            (k == 0) ? ro_data[k*DW +: DW] : shadow_r[k*DW +: DW];
`else
                rd_data_s = (ar_idx_s == 32'(k)) ? ro_data[k*DW +: DW] : rd_data_s;
`endif
            end
        end else if (ar_idx_s < (N_RO_U + N_RW_U)) begin
            rd_resp_s = RESP_OKAY;
            for (int j = 0; j < NRW_EFF; j++) begin
                rd_data_s = (ar_idx_s == (N_RO_U + 32'(j))) ? rw_r[j] : rd_data_s;
            end
        end else begin
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Control registers: byte-strobed update of the selected word on commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int j = 0; j < NRW_EFF; j++) begin
                rw_r[j] <= RW_RESET;
            end
        end else begin
            for (int j = 0; j < NRW_EFF; j++) begin
                for (int b = 0; b < SW; b++) begin
                    if (commit_s && wr_ok_s && (rw_sel_s == RW_SEL_W'(j)) && w_strb_s[b]) begin
                        rw_r[j][8*b +: 8] <= w_data_s[8*b +: 8];
                    end else begin
                        rw_r[j][8*b +: 8] <= rw_r[j][8*b +: 8];
                    end
                end
            end
        end
    end

    // One-cycle write strobe, aligned with the updated control word.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_pulse_r <= {NRW_EFF{1'b0}};
        end else begin
            for (int j = 0; j < NRW_EFF; j++) begin
                wr_pulse_r[j] <= commit_s && wr_ok_s && (rw_sel_s == RW_SEL_W'(j));
            end
        end
    end

    // B channel: raised on commit, held with stable BRESP until BREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r && S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
        end else begin
            bvalid_r <= bvalid_r;
        end
    end

    // R channel: register the read on the AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_r <= 1'b0;
            rresp_r  <= 2'b00;
            rdata_r  <= {DW{1'b0}};
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_resp_s;
            rdata_r  <= rd_data_s;
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end

    for (genvar g = 0; g < NRW_EFF; g++) begin : g_rw_out
        assign rw_data[g*DW +: DW] = rw_r[g];
    end

    assign wr_pulse      = wr_pulse_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = ~rvalid_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank (default parameters). Stimulus pushes
// expected B/R responses into queues; a monitor pops and compares them at
// each handshake and tallies wr_pulse strobes.
module tb_axi_lite_regbank;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   awaddr = 6'd0, araddr = 6'd0;
    logic [2:0]   awprot = 3'd0, arprot = 3'd0;
    logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic         bready = 1'b1, rready = 1'b1;
    logic [31:0]  wdata = 32'd0;
    logic [3:0]   wstrb = 4'd0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] ro_data;
    logic [127:0] rw_data;
    logic [3:0]   wr_pulse;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } r_exp_t;

    logic [1:0] b_q[$];
    r_exp_t     r_q[$];
    int n_checks = 0, n_fail = 0;
    int b_seen = 0, b_target = 0, r_seen = 0, r_target = 0;
    int pulse_cnt[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    axi_lite_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ro_data(ro_data), .rw_data(rw_data), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each B/R handshake against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) chk("b_unexpected", 128'd1, 128'd0);
                else chk("bresp", bresp, b_q.pop_front());
                b_seen++;
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) chk("r_unexpected", 128'd1, 128'd0);
                else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rresp", rresp, e.r);
                end
                r_seen++;
            end
            for (int j = 0; j < 4; j++) if (wr_pulse[j]) pulse_cnt[j]++;
        end
    end

    task automatic do_aw(input logic [5:0] a);
        bit ok = 1'b0;
        @(posedge clk); #1;
        awaddr = a; awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (!ok) chk("aw_accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        @(posedge clk); #1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
        if (!ok) chk("w_accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_ar(input logic [5:0] a);
        bit ok = 1'b0;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!ok) chk("ar_accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_b();
        for (int n = 0; n < 100 && b_seen < b_target; n++) @(negedge clk);
        if (b_seen < b_target) chk("b_timeout", 128'(b_seen), 128'(b_target));
    endtask

    task automatic wait_r();
        for (int n = 0; n < 100 && r_seen < r_target; n++) @(negedge clk);
        if (r_seen < r_target) chk("r_timeout", 128'(r_seen), 128'(r_target));
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
        b_q.push_back(resp);
        b_target++;
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_b();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp);
        r_q.push_back('{d: d, r: resp});
        r_target++;
        do_ar(a);
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_data;
        bit seen;
        ro_data = {32'hBEEF0003, 32'hCAFE0002, 32'h00000011, 32'h000000AA};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rw_data", rw_data, 128'd0);
        chk("rst_wr_pulse", wr_pulse, 4'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Read RW1 after reset, strobed write to RW2
        axi_read(6'h14, 32'h00000000, 2'b00);
        chk("rw1_after_reset", rw_data[63:32], 32'd0);
        axi_write(6'h18, 32'hA5A5A5A5, 4'b0101, 2'b00);
        chk("rw2_strobed", rw_data[95:64], 32'h00A500A5);
        axi_read(6'h18, 32'h00A500A5, 2'b00);
        chk("pulse2_once", 128'(pulse_cnt[2]), 128'd1);

        // Write to RO index, out-of-range read
        axi_write(6'h00, 32'hFFFFFFFF, 4'b1111, 2'b10);
        chk("ro_write_no_pulse", 128'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 128'd1);
        axi_read(6'h3C, 32'h00000000, 2'b10);

        // Status reads (index 0 also refreshes any shadow bank)
        axi_read(6'h00, 32'h000000AA, 2'b00);
        axi_read(6'h08, 32'hCAFE0002, 2'b00);

        // More control patterns, including an all-zero strobe
        axi_write(6'h10, 32'h12345678, 4'b1111, 2'b00);
        axi_write(6'h1C, 32'hDEADBEEF, 4'b1100, 2'b00);
        axi_write(6'h14, 32'hFFFFFFFF, 4'b0000, 2'b00);
        axi_read(6'h10, 32'h12345678, 2'b00);
        axi_read(6'h1C, 32'hDEAD0000, 2'b00);
        axi_read(6'h14, 32'h00000000, 2'b00);
        chk("pulse0", 128'(pulse_cnt[0]), 128'd1);
        chk("pulse1_zero_strobe", 128'(pulse_cnt[1]), 128'd1);
        chk("pulse3", 128'(pulse_cnt[3]), 128'd1);

        // W three cycles ahead of AW, BREADY low for five cycles
        bready = 1'b0;
        b_q.push_back(2'b00);
        b_target++;
        do_w(32'h0000BEEF, 4'b1111);
        repeat (3) @(posedge clk);
        chk("w_only_no_b", bvalid, 1'b0);
        do_aw(6'h14);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = bvalid;
        end
        chk("b_raised", seen, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("b_hold_valid", bvalid, 1'b1);
            chk("b_hold_resp", bresp, 2'b00);
        end
        chk("one_commit_pulse1", 128'(pulse_cnt[1]), 128'd2);
        chk("rw1_beef", rw_data[63:32], 32'h0000BEEF);
        @(posedge clk); #1 bready = 1'b1;
        wait_b();
        chk("pulse1_after_b", 128'(pulse_cnt[1]), 128'd2);

        // RREADY low for four cycles after a read of index 1
        rready = 1'b0;
        r_q.push_back('{d: 32'h00000011, r: 2'b00});
        r_target++;
        do_ar(6'h04);
        held_data = 32'h00000011;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("r_hold_data", rdata, held_data);
            chk("r_hold_arready", arready, 1'b0);
            chk("r_hold_valid", rvalid, 1'b1);
        end
        @(posedge clk); #1 rready = 1'b1;
        wait_r();

        // Snapshot behaviour on status word 1
        axi_read(6'h00, 32'h000000AA, 2'b00);
        ro_data[63:32] = 32'h00000022;
`ifdef AXI_REGBANK_SNAPSHOT_EN
        axi_read(6'h04, 32'h00000011, 2'b00);
`else
        axi_read(6'h04, 32'h00000022, 2'b00);
`endif

        // Reset with an address held: nothing pending afterwards
        do_aw(6'h10);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_awready", awready, 1'b1);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_rw_data", rw_data, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_w(32'h55555555, 4'b1111);
        repeat (4) @(negedge clk);
        chk("post_rst_no_b", bvalid, 1'b0);
        chk("post_rst_rw0", rw_data[31:0], 32'd0);
        chk("b_queue_empty", 128'(b_q.size()), 128'd0);
        chk("r_queue_empty", 128'(r_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 The parameter AXI_DATA_WIDTH SHALL default to 32 and set the data width; the legal values are 32 and 64.
REQ-002 The parameter AXI_ADDR_WIDTH SHALL default to 6 and set the byte address width.
REQ-003 The parameter N_RO SHALL default to 4 and set the number of read-only status registers (1..16).
REQ-004 The parameter N_RW SHALL default to 4 and set the number of read/write control registers (0..16).
REQ-005 The parameter RW_RESET SHALL default to 0; it is the reset value of every RW register, and its width is AXI_DATA_WIDTH.
REQ-006 The port S_AXI_ACLK SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The port S_AXI_ARESETN SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The AXI4-Lite slave ports SHALL be S_AXI_AW*/W*/B*/AR*/R* with the standard directions; data ports are AXI_DATA_WIDTH wide, strobes are AXI_DATA_WIDTH/8, addresses are AXI_ADDR_WIDTH, and AWPROT/ARPROT are ignored.
REQ-009 The port ro_data SHALL be an input of N_RO*AXI_DATA_WIDTH bits: the status words, with register k in slice k.
REQ-010 The port rw_data SHALL be an output of max(N_RW,1)*AXI_DATA_WIDTH bits: the current control register contents.
REQ-011 The port wr_pulse SHALL be an output of max(N_RW,1) bits: a one-cycle strobe, bit j, on each accepted write to RW register j.

Function
REQ-012 The address map SHALL be word index = addr[ADDR_LSB +: IDX_W], with ADDR_LSB = 2 for 32-bit data and 3 for 64-bit data; indices 0..N_RO-1 are RO and N_RO..N_RO+N_RW-1 are RW.
REQ-013 AW and W SHALL be accepted independently: each has a one-entry holding register, with awready = ~aw_held and wready = ~w_held.
REQ-014 A write SHALL commit in the cycle where both entries are held and bvalid is low; that cycle updates the register, clears both held flags and sets bvalid on the next edge.
REQ-015 If AW and W handshake in the same cycle on an idle slave, bvalid SHALL assert two edges later; if one arrives before the other, the commit waits for the second.
REQ-016 A write commit SHALL update only the bytes whose WSTRB bit is 1; WSTRB = 0 gives BRESP OKAY, changes nothing, and wr_pulse still fires.
REQ-017 A write to an RO index or to an out-of-range index SHALL produce no state change, no wr_pulse, and BRESP = SLVERR (2'b10).
REQ-018 bvalid SHALL stay high with BRESP stable until BREADY; new AW/W beats MAY be held while bvalid is pending, but they commit only after the B handshake.
REQ-019 arready SHALL equal ~rvalid; an AR handshake SHALL register RDATA/RRESP and set rvalid on the same edge, giving a latency of 1 cycle.
REQ-020 RDATA and RRESP SHALL stay stable while rvalid & ~RREADY; an out-of-range read SHALL return RDATA = 0 with RRESP = SLVERR.
REQ-021 Reads and writes SHALL proceed concurrently; a read of an RW register in its commit cycle SHALL return the pre-write value.
REQ-022 wr_pulse SHALL be high for exactly the cycle after the commit, aligned with the new rw_data value.

Reset
REQ-023 While S_AXI_ARESETN = 0, the following SHALL hold: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, BRESP=0, RRESP=0, RDATA=0, wr_pulse=0, held flags cleared, and rw_data = RW_RESET.
REQ-024 A reset asserted mid-transaction SHALL abandon the in-flight write or read with no register update and no pending response after release.

Configuration
REQ-025 With AXI_REGBANK_SNAPSHOT_EN defined, an AR handshake to index 0 SHALL latch all of ro_data into a shadow bank on the same edge.
REQ-026 With AXI_REGBANK_SNAPSHOT_EN defined, reads of RO indices 1..N_RO-1 SHALL return the shadow value, and the shadow bank SHALL reset to 0.
REQ-027 Without AXI_REGBANK_SNAPSHOT_EN, every RO read SHALL sample ro_data live, and no shadow storage is synthesised.

Structure
REQ-028 The package axi_regbank_pkg SHALL hold the response codes (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and the functions addr_lsb(dw) and idx_w(n).
REQ-029 The sub-module axi_lite_hold SHALL implement the one-entry valid/ready holding register, parametrised on width, and SHALL be instantiated for AW and for W.

Verification
REQ-030 After reset, reading index 5 (byte address 0x14, default parameters) SHALL return RDATA=0x00000000 and OKAY, with rw_data[1]=0.
REQ-031 Writing 0xA5A5A5A5 to address 0x18 with WSTRB=4'b0101 and then reading it back SHALL give 0x00A500A5, with one wr_pulse[2] pulse.
REQ-032 A write to address 0x00 (RO) SHALL give BRESP=SLVERR and leave wr_pulse at 0; a read of address 0x3C SHALL give RDATA=0 with SLVERR.
REQ-033 With W presented three cycles before AW and BREADY held low for five cycles, exactly one commit SHALL occur, and bvalid and BRESP SHALL stay stable until BREADY.
REQ-034 With RREADY held low for four cycles after a read of index 1, RDATA SHALL stay constant and arready SHALL stay 0 until the R handshake.
REQ-035 With SNAPSHOT_EN defined: read index 0, change ro_data[1] from 0x11 to 0x22, then read index 1 SHALL return 0x11; without SNAPSHOT_EN the same sequence SHALL return 0x22.
